// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: reader for a fall-through FIFO that serialises each popped
// word onto an asynchronous TX line (start bit, LSB-first data, stop bits).
// Consecutive words are sent back to back with no idle gap between frames.
module fifo_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_q,
  input  logic             fifo_q_ready,
  output logic             fifo_q_out_strobe,
  output logic             tx,
  output logic             busy
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW        = $clog2(STOP_CLKS);
  localparam int IW        = $clog2(WIDTH) + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CLKS - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic             bit_done;
  logic             stop_done;
  logic             take;
  logic [WIDTH-1:0] shreg_shift;

  assign bit_done    = (cnt_q == BIT_LAST);
  assign stop_done   = (cnt_q == STOP_LAST);
  assign shreg_shift = shreg_q >> 1;

  // A pop happens only when idle or on the final stop cycle, so a new frame
  // can chain straight onto the previous one; reset suppresses the pop.
  assign take = enable & fifo_q_ready & ~reset &
                ((state_q == IDLE) | ((state_q == STOP) & stop_done));

  assign fifo_q_out_strobe = take;
  assign tx                = tx_q;
  assign busy              = busy_q;

  // Next-state, counters, shift register and registered line outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (take) begin
          shreg_d = fifo_q;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + IW'(1);
            shreg_d = shreg_shift;
            tx_d    = shreg_shift[0];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (stop_done) begin
          cnt_d = '0;
          bit_d = '0;
          if (take) begin
            shreg_d = fifo_q;
            state_d = START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx: a one-stop-bit instance and a two-stop-bit
// instance, each fed by a small fall-through FIFO model kept in the bench.
module tb_fifo_serial_tx;

  localparam int W   = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         enable;
  logic [W-1:0] fifo_q, fifo_q2;
  logic         rdy, rdy2;
  logic         strobe, strobe2;
  logic         tx, tx2;
  logic         busy, busy2;

  logic [W-1:0] q[$];
  logic [W-1:0] q2[$];

  int   checks = 0;
  int   errors = 0;
  logic p, p2;

  fifo_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_q(fifo_q), .fifo_q_ready(rdy), .fifo_q_out_strobe(strobe),
    .tx(tx), .busy(busy)
  );

  fifo_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_q(fifo_q2), .fifo_q_ready(rdy2), .fifo_q_out_strobe(strobe2),
    .tx(tx2), .busy(busy2)
  );

  // Present the FIFO heads to both DUTs.
  task automatic refresh();
    rdy  = (q.size() > 0);
    rdy2 = (q2.size() > 0);
    if (rdy) fifo_q = q[0];
    else     fifo_q = 8'h00;
    if (rdy2) fifo_q2 = q2[0];
    else      fifo_q2 = 8'h00;
  endtask

  // One clock: sample strobes mid-cycle, pop on the edge, settle inputs at +1.
  task automatic step();
    @(negedge clk);
    p  = strobe;
    p2 = strobe2;
    @(posedge clk);
    #1;
    if (p  && q.size()  > 0) q.delete(0);
    if (p2 && q2.size() > 0) q2.delete(0);
    refresh();
  endtask

  // Expected line level n cycles after a take cycle (n >= 1), within one frame.
  function automatic logic exp_tx(input logic [W-1:0] d, input int n);
    if (n <= CPB)             return 1'b0;
    else if (n <= CPB*(1+W))  return d[(n-1)/CPB - 1];
    else                      return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    refresh();
    step(); step();
    q.push_back(8'hA5); refresh();
    step();
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b expected 0", p); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx2 got %b expected 1", tx2); end
    reset = 1'b0;
    // word queued during reset is taken in the first cycle after release
    for (int n = 1; n <= 41; n++) begin
      step();
      if (n == 1) begin
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL post_reset_take got %b expected 1", p); end
      end
      checks++;
      if (tx !== ((n <= 40) ? exp_tx(8'hA5, n) : 1'b1)) begin
        errors++; $display("FAIL post_reset_tx n=%0d got %b expected %b", n, tx, exp_tx(8'hA5, n));
      end
    end
  endtask

  task automatic test_single_frame();
    int ns;
    ns = 0;
    q.push_back(8'h55); refresh();
    for (int n = 1; n <= 41; n++) begin
      step();
      if (p) ns++;
      checks++;
      if (tx !== ((n <= 40) ? exp_tx(8'h55, n) : 1'b1)) begin
        errors++; $display("FAIL single_tx n=%0d got %b expected %b", n, tx, exp_tx(8'h55, n));
      end
      checks++;
      if (busy !== (n <= 40)) begin
        errors++; $display("FAIL single_busy n=%0d got %b expected %b", n, busy, (n <= 40));
      end
    end
    checks++; if (ns !== 1) begin errors++; $display("FAIL single_strobes got %0d expected 1", ns); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL single_empty got %0d expected 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    int ns, first, second;
    logic e;
    ns = 0; first = -1; second = -1;
    q.push_back(8'h55); q.push_back(8'hAA); refresh();
    for (int n = 1; n <= 81; n++) begin
      step();
      if (p) begin
        if (ns == 0) first = n - 1;
        else         second = n - 1;
        ns++;
      end
      if (n <= 40)      e = exp_tx(8'h55, n);
      else if (n <= 80) e = exp_tx(8'hAA, n - 40);
      else              e = 1'b1;
      checks++;
      if (tx !== e) begin errors++; $display("FAIL b2b_tx n=%0d got %b expected %b", n, tx, e); end
      checks++;
      if (busy !== (n <= 80)) begin
        errors++; $display("FAIL b2b_busy n=%0d got %b expected %b", n, busy, (n <= 80));
      end
    end
    checks++; if (ns !== 2) begin errors++; $display("FAIL b2b_strobes got %0d expected 2", ns); end
    checks++;
    if (second - first !== 40) begin
      errors++; $display("FAIL b2b_spacing got %0d expected 40", second - first);
    end
  endtask

  task automatic test_empty();
    for (int n = 0; n < 50; n++) begin
      step();
      checks++;
      if (p !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL empty_idle n=%0d got strobe=%b tx=%b busy=%b expected 0/1/0", n, p, tx, busy);
      end
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    q.push_back(8'hFF); refresh();
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (p !== 1'b0 || tx !== 1'b1) begin
        errors++; $display("FAIL enable_hold n=%0d got strobe=%b tx=%b expected 0/1", n, p, tx);
      end
    end
    enable = 1'b1;
    step();
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL enable_take got %b expected 1", p); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL enable_txfall got %b expected 0", tx); end
    for (int n = 2; n <= 41; n++) begin
      step();
      checks++;
      if (tx !== ((n <= 40) ? exp_tx(8'hFF, n) : 1'b1)) begin
        errors++; $display("FAIL enable_tx n=%0d got %b expected %b", n, tx, exp_tx(8'hFF, n));
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL enable_done got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset();
    q.push_back(8'h0F); q.push_back(8'h33); refresh();
    // run until cycle 18, inside data bit 3
    for (int n = 1; n <= 18; n++) begin
      step();
      checks++;
      if (tx !== exp_tx(8'h0F, n)) begin
        errors++; $display("FAIL midrst_pre n=%0d got %b expected %b", n, tx, exp_tx(8'h0F, n));
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL midrst_strobe got %b expected 0", p); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
    checks++; if (q.size() !== 1) begin errors++; $display("FAIL midrst_fifo got %0d expected 1", q.size()); end
    for (int n = 1; n <= 41; n++) begin
      step();
      if (n == 1) begin
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL midrst_retake got %b expected 1", p); end
      end
      checks++;
      if (tx !== ((n <= 40) ? exp_tx(8'h33, n) : 1'b1)) begin
        errors++; $display("FAIL midrst_tx33 n=%0d got %b expected %b", n, tx, exp_tx(8'h33, n));
      end
    end
  endtask

  task automatic test_two_stop();
    int ns, second;
    logic e;
    ns = 0; second = -1;
    q2.push_back(8'h00); q2.push_back(8'h80); refresh();
    for (int n = 1; n <= 89; n++) begin
      step();
      if (p2) begin
        if (ns == 1) second = n - 1;
        ns++;
      end
      if (n <= 36)      e = 1'b0;
      else if (n <= 44) e = 1'b1;
      else if (n <= 80) e = exp_tx(8'h80, n - 44);
      else              e = 1'b1;
      checks++;
      if (tx2 !== e) begin errors++; $display("FAIL stop2_tx n=%0d got %b expected %b", n, tx2, e); end
      checks++;
      if (busy2 !== (n <= 88)) begin
        errors++; $display("FAIL stop2_busy n=%0d got %b expected %b", n, busy2, (n <= 88));
      end
    end
    checks++; if (ns !== 2) begin errors++; $display("FAIL stop2_strobes got %0d expected 2", ns); end
    checks++; if (second !== 44) begin errors++; $display("FAIL stop2_second got %0d expected 44", second); end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    p = 1'b0;
    p2 = 1'b0;
    refresh();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_empty();
    test_enable();
    test_mid_reset();
    test_two_stop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
